// File: rtl/csa_pkg.sv
// Shared constants for the hierarchical carry-select adder.
//   ADD_W   : full adder width in bits
//   GRP_W   : width of one ripple-carry group
//   NUM_GRP : number of groups across the full width
package csa_pkg;

    localparam int ADD_W   = 16;
    localparam int GRP_W   = 4;
    localparam int NUM_GRP = ADD_W / GRP_W;

    typedef logic [ADD_W-1:0] word_t;
    typedef logic [GRP_W-1:0] grp_t;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder built from full-adder equations.
// Ports:
//   a, b : group operands
//   ci   : carry into bit 0
//   s    : group sum
//   co   : carry out of the top bit
module rca4
    import csa_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             ci,
    output logic [GRP_W-1:0] s,
    output logic             co
);

    logic carry;

    // NOTE: blocking assignments here are deliberate. 'carry' is a
    // combinational temporary that must update bit by bit inside the loop.
    always_comb begin
        carry = ci;
        s     = '0;
        for (int i = 0; i < GRP_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

    assign co = carry;

endmodule

// File: rtl/hier_csa_adder_16.sv
// 16-bit hierarchical carry-select adder with a registered, valid-qualified output.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : a/b/cin are meaningful this cycle
//   a, b      : unsigned operands
//   cin       : carry-in
//   out_valid : sum/cout were loaded on the last edge
//   sum       : registered (a + b + cin)[15:0]
//   cout      : registered (a + b + cin)[16]
module hier_csa_adder_16
    import csa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    // Level 0: G0 ripples from cin; G1..G3 are speculated for both carry-ins.
    grp_t                            g0_s;
    logic                            g0_co;
    logic [NUM_GRP-1:1][GRP_W-1:0]   s_c0, s_c1;
    logic [NUM_GRP-1:1]              co_c0, co_c1;

    rca4 u_g0 (
        .a  (a[GRP_W-1:0]),
        .b  (b[GRP_W-1:0]),
        .ci (cin),
        .s  (g0_s),
        .co (g0_co)
    );

    for (genvar g = 1; g < NUM_GRP; g++) begin : g_grp
        rca4 u_c0 (
            .a  (a[g*GRP_W +: GRP_W]),
            .b  (b[g*GRP_W +: GRP_W]),
            .ci (1'b0),
            .s  (s_c0[g]),
            .co (co_c0[g])
        );
        rca4 u_c1 (
            .a  (a[g*GRP_W +: GRP_W]),
            .b  (b[g*GRP_W +: GRP_W]),
            .ci (1'b1),
            .s  (s_c1[g]),
            .co (co_c1[g])
        );
    end

    // Level 1, low byte: the real G0 carry picks the G1 variant.
    grp_t g1_s;
    logic lo_co;

    assign g1_s  = g0_co ? s_c1[1]  : s_c0[1];
    assign lo_co = g0_co ? co_c1[1] : co_c0[1];

    // Level 1, high byte: two 8-bit sub-chains, one per assumed byte carry-in.
    // Inside each chain the G2 carry (for that assumption) picks the G3 variant.
    logic [2*GRP_W-1:0] hi0_s, hi1_s;
    logic               hi0_co, hi1_co;

    assign hi0_s  = {(co_c0[2] ? s_c1[3] : s_c0[3]), s_c0[2]};
    assign hi0_co =   co_c0[2] ? co_c1[3] : co_c0[3];
    assign hi1_s  = {(co_c1[2] ? s_c1[3] : s_c0[3]), s_c1[2]};
    assign hi1_co =   co_c1[2] ? co_c1[3] : co_c0[3];

    // Level 2: the real low-byte carry picks the high-byte result.
    word_t core_sum;
    logic  core_co;

    assign core_sum = {(lo_co ? hi1_s : hi0_s), g1_s, g0_s};
    assign core_co  =   lo_co ? hi1_co : hi0_co;

    // Output stage: sum/cout only load on valid input and otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= core_sum;
                cout <= core_co;
            end
        end
    end

endmodule

// File: tb/tb_hier_csa_adder_16.sv
// Self-checking bench for hier_csa_adder_16: directed corner cases plus
// random traffic compared against a plain-arithmetic 17-bit reference.
module tb_hier_csa_adder_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the registered outputs should hold after each edge.
    logic [15:0] m_sum   = '0;
    logic        m_cout  = 1'b0;
    logic        m_valid = 1'b0;

    hier_csa_adder_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus on the falling edge, advance the reference
    // at the rising edge, then compare all outputs just after it.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] total;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        if (!r) begin
            m_sum   = '0;
            m_cout  = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                total  = 17'(x) + 17'(y) + 17'(c);
                m_sum  = total[15:0];
                m_cout = total[16];
            end
        end
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".sum"},   32'(sum),       32'(m_sum));
        check({tag, ".cout"},  32'(cout),      32'(m_cout));
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t dir[10];

    initial begin
        dir[0] = '{16'd4,     16'd5,     1'b0, 16'd9,     1'b0};
        dir[1] = '{16'd8,     16'd6,     1'b1, 16'd15,    1'b0};
        dir[2] = '{16'd9,     16'd9,     1'b1, 16'd19,    1'b0};
        dir[3] = '{16'd4,     16'd8,     1'b0, 16'd12,    1'b0};
        dir[4] = '{16'd655,   16'd1,     1'b0, 16'd656,   1'b0};
        dir[5] = '{16'h000F,  16'h0001,  1'b0, 16'h0010,  1'b0};
        dir[6] = '{16'h00FF,  16'h0001,  1'b0, 16'h0100,  1'b0};
        dir[7] = '{16'h0FFF,  16'h0000,  1'b1, 16'h1000,  1'b0};
        dir[8] = '{16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1};
        dir[9] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1};

        // Reset held two cycles while in_valid and all-ones operands are presented.
        step("rst0", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        step("rst1", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        check("rst.sum_zero", 32'(sum), 32'h0);

        // Back-to-back directed vectors, also checked against literal results.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("dir%0d", i), 1'b1, 1'b1, dir[i].x, dir[i].y, dir[i].c);
            check($sformatf("dir%0d.lit_sum", i),  32'(sum),  32'(dir[i].s));
            check($sformatf("dir%0d.lit_cout", i), 32'(cout), 32'(dir[i].co));
        end

        // Valid gating: operands change but the outputs must hold.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold%0d", i), 1'b1, 1'b0, 16'(16'h1234 * (i + 1)), 16'h0F0F, 1'b1);
            check($sformatf("hold%0d.lit_sum", i), 32'(sum), 32'hFFFF);
        end

        // Mid-stream reset with a valid input pending: reset wins.
        step("pre_rst", 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0);
        step("mid_rst", 1'b0, 1'b1, 16'h4444, 16'h5555, 1'b1);
        step("post_rst", 1'b1, 1'b1, 16'h7000, 16'h9000, 1'b1);
        check("post_rst.lit_sum", 32'(sum), 32'h0001);

        // Random traffic: mostly valid, occasional idle cycles and resets.
        for (int i = 0; i < 10000; i++) begin
            step("rnd",
                 ($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) != 0),
                 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
